// File: rtl/ahb_spi_if.sv
// ahb_spi_if -- AHB-Lite slave port bundle for ahb_spi.
//
// Signals (AHB naming kept so the bundle maps 1:1 onto the system bus):
//   HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA : master -> slave
//   HRDATA, HREADYOUT                                  : slave  -> master
// Modports:
//   slave  : used by ahb_spi
//   master : used by the bus side (decoder / testbench)

interface ahb_spi_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport slave (
        input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
        output HRDATA, HREADYOUT
    );

    modport master (
        output HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
        input  HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_spi.sv
// ahb_spi -- zero-wait-state AHB-Lite slave driving an SPI master (mode 0).
// Software owns the slave selects and queues 1/2/4-byte bursts; the display
// controller sits on slave select 0.
//
// Ports:
//   HCLK        in   single clock for all logic
//   HRESET      in   synchronous, active-high reset
//   bus         ahb_spi_if.slave  AHB-Lite slave port
//   SPI_MISO_i  in   serial data in
//   SPI_MOSI_o  out  serial data out
//   SPI_SS_o    out  [31:0] slave selects, active low, straight from SSEL
//   SPI_CLK_o   out  SPI clock, idle low
//
// Registers (HADDR[3:2]):
//   0x0 STATUS  RO  [0] busy, [4] done (sticky), [5] overrun (sticky), [10:8] bytes left
//   0x4 SSEL    RW
//   0x8 TXDATA  WO  byte count from HSIZE, reads return 0
//   0xC RXDATA  RO  last 32 bits shifted in, newest at [0]
//
// Configuration macro: AHBSPI_LOOPBACK_EN -- when defined, the receive shifter
// takes SPI_MOSI_o instead of SPI_MISO_i; pins are otherwise unchanged.

module ahb_spi #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    ahb_spi_if.slave    bus,
    input  logic        SPI_MISO_i,
    output logic        SPI_MOSI_o,
    output logic [31:0] SPI_SS_o,
    output logic        SPI_CLK_o
);

    typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi} state_e;

    localparam logic [31:0] DivLast = 32'(CLK_DIV - 1);

    state_e      state_q;
    logic [31:0] div_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [31:0] ss_q;
    logic [4:0]  bits_q;     // bits still to send after the current one
    logic        done_q;
    logic        ovr_q;
    logic        mosi_q;
    logic        sclk_q;

    // Captured address phase
    logic        dp_valid_q;
    logic        dp_write_q;
    logic [1:0]  dp_addr_q;
    logic [2:0]  dp_size_q;

    logic        busy;
    logic        addr_ok;
    logic        tx_wr;
    logic        tx_size_ok;
    logic        shift_in;
    logic [31:0] tx_load;
    logic [4:0]  bits_load;
    logic [2:0]  bytes_rem;
    logic [31:0] status;

    assign busy       = (state_q != StIdle);
    assign addr_ok    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign tx_wr      = dp_valid_q & dp_write_q & (dp_addr_q == 2'd2);
    assign tx_size_ok = (dp_size_q <= 3'd2);

`ifdef AHBSPI_LOOPBACK_EN
    assign shift_in = mosi_q;
    logic unused_miso;
    assign unused_miso = SPI_MISO_i;
`else
    assign shift_in = SPI_MISO_i;
`endif

    logic unused_bus;
    assign unused_bus = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0]};

    // Left-align the written bytes so bit 31 is always the next bit out.
    always_comb begin
        tx_load   = bus.HWDATA;
        bits_load = 5'd31;
        unique case (dp_size_q[1:0])
            2'd0: begin
                tx_load   = {bus.HWDATA[7:0], 24'h0};
                bits_load = 5'd7;
            end
            2'd1: begin
                tx_load   = {bus.HWDATA[15:0], 16'h0};
                bits_load = 5'd15;
            end
            default: ;
        endcase
    end

    assign bytes_rem = busy ? ({1'b0, bits_q[4:3]} + 3'd1) : 3'd0;
    assign status    = {21'h0, bytes_rem, 2'b00, ovr_q, done_q, 3'b000, busy};

    always_comb begin
        bus.HRDATA = 32'h0;
        if (dp_valid_q && !dp_write_q) begin
            unique case (dp_addr_q)
                2'd0:    bus.HRDATA = status;
                2'd1:    bus.HRDATA = ss_q;
                2'd3:    bus.HRDATA = rx_q;
                default: bus.HRDATA = 32'h0;
            endcase
        end
    end

    assign bus.HREADYOUT = 1'b1;
    assign SPI_MOSI_o    = mosi_q;
    assign SPI_SS_o      = ss_q;
    assign SPI_CLK_o     = sclk_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StIdle;
            div_q      <= 32'h0;
            tx_q       <= 32'h0;
            rx_q       <= 32'h0;
            ss_q       <= 32'hFFFF_FFFF;
            bits_q     <= 5'd0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
            dp_size_q  <= 3'd0;
        end else begin
            dp_valid_q <= addr_ok;
            if (addr_ok) begin
                dp_write_q <= bus.HWRITE;
                dp_addr_q  <= bus.HADDR[3:2];
                dp_size_q  <= bus.HSIZE;
            end

            if (dp_valid_q && dp_write_q && (dp_addr_q == 2'd1)) begin
                ss_q <= bus.HWDATA;
            end
            // A STATUS read and a TXDATA write never share a data phase.
            if (dp_valid_q && !dp_write_q && (dp_addr_q == 2'd0)) begin
                ovr_q <= 1'b0;
            end
            if (tx_wr && tx_size_ok && busy) begin
                ovr_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tx_wr && tx_size_ok) begin
                        state_q <= StShiftLo;
                        div_q   <= 32'h0;
                        tx_q    <= tx_load;
                        mosi_q  <= tx_load[31];
                        bits_q  <= bits_load;
                        done_q  <= 1'b0;
                    end
                end
                StShiftLo: begin
                    if (div_q == DivLast) begin
                        state_q <= StShiftHi;
                        div_q   <= 32'h0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[30:0], shift_in};
                    end else begin
                        div_q <= div_q + 32'd1;
                    end
                end
                StShiftHi: begin
                    if (div_q == DivLast) begin
                        div_q  <= 32'h0;
                        sclk_q <= 1'b0;
                        if (bits_q == 5'd0) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            state_q <= StShiftLo;
                            bits_q  <= bits_q - 5'd1;
                            tx_q    <= {tx_q[30:0], 1'b0};
                            mosi_q  <= tx_q[30];
                        end
                    end else begin
                        div_q <= div_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_spi.sv
// tb_ahb_spi -- self-checking bench for ahb_spi (CLK_DIV = 4).
// An SPI slave-0 monitor logs received bytes, counts SCLK pulses and drives
// MISO from a fixed pattern; expected bytes are queued when TXDATA is written
// and popped against the monitor's log once the burst completes.

module tb_ahb_spi;

    localparam int unsigned CLK_DIV  = 4;
    localparam logic [31:0] MISO_PAT = 32'h9E37_79B9;
`ifdef AHBSPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        SPI_MISO_i = MISO_PAT[31];
    logic        SPI_MOSI_o;
    logic [31:0] SPI_SS_o;
    logic        SPI_CLK_o;

    ahb_spi_if bus ();

    ahb_spi #(.CLK_DIV(CLK_DIV)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus),
        .SPI_MISO_i (SPI_MISO_i),
        .SPI_MOSI_o (SPI_MOSI_o),
        .SPI_SS_o   (SPI_SS_o),
        .SPI_CLK_o  (SPI_CLK_o)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] model_rx;

    function automatic logic mbit(input int k);
        logic [31:0] p;
        p = MISO_PAT;
        return p[31 - (k % 32)];
    endfunction

    function automatic logic [31:0] rx_after(input logic [31:0] prev, input logic [31:0] txd,
                                             input int nbits, input int p0);
        logic [31:0] r;
        r = prev;
        for (int i = 0; i < nbits; i++) begin
            r = {r[30:0], LOOPBACK ? txd[nbits - 1 - i] : mbit(p0 + i)};
        end
        return r;
    endfunction

    // ---------------- SPI slave 0 monitor (sampled on falling HCLK) ----------------
    int         cyc = 0;
    int         pulse_total = 0;
    int         byte_cnt = 0;
    int         last_fall_cyc = 0;
    int         bit_in_byte = 0;
    logic       sclk_prev = 1'b0;
    logic [7:0] shift_byte = 8'h0;
    logic [7:0] byte_log [64];

    always @(negedge HCLK) begin
        cyc       <= cyc + 1;
        sclk_prev <= SPI_CLK_o;
        if (HRESET) begin
            bit_in_byte <= 0;
        end else if (SPI_CLK_o && !sclk_prev) begin
            pulse_total <= pulse_total + 1;
            SPI_MISO_i  <= mbit(pulse_total + 1);
            if (!SPI_SS_o[0]) begin
                if (bit_in_byte == 7) begin
                    byte_log[byte_cnt % 64] <= {shift_byte[6:0], SPI_MOSI_o};
                    byte_cnt    <= byte_cnt + 1;
                    bit_in_byte <= 0;
                end else begin
                    shift_byte  <= {shift_byte[6:0], SPI_MOSI_o};
                    bit_in_byte <= bit_in_byte + 1;
                end
            end
        end else if (!SPI_CLK_o && sclk_prev) begin
            last_fall_cyc <= cyc;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data);
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = size;
        @(negedge HCLK);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = data;
        @(posedge HCLK);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        @(negedge HCLK);
        data       = bus.HRDATA;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(posedge HCLK);
    endtask

    task automatic wait_done(output logic [31:0] st);
        int guard;
        guard = 0;
        ahb_read(32'h0, st);
        while (st[0] && guard < 400) begin
            ahb_read(32'h0, st);
            guard++;
        end
        n_checks++;
        if (st[0]) begin
            n_fail++;
            $display("FAIL burst_timeout: status=%08h required busy=0", st);
        end
    endtask

    task automatic check_bytes(input int b0);
        logic [7:0] e;
        int         idx;
        idx = b0;
        n_checks++;
        if (byte_cnt - b0 != exp_q.size()) begin
            n_fail++;
            $display("FAIL byte_count: got %0d required %0d", byte_cnt - b0, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (byte_log[idx % 64] !== e) begin
                n_fail++;
                $display("FAIL slave0_byte[%0d]: got %02h required %02h",
                         idx - b0, byte_log[idx % 64], e);
            end
            idx++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        model_rx = 32'h0;
        @(negedge HCLK);
        n_checks++;
        if (SPI_CLK_o !== 1'b0 || SPI_MOSI_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pins: clk=%b mosi=%b required 0 0", SPI_CLK_o, SPI_MOSI_o);
        end
        n_checks++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: hreadyout=%b hrdata=%08h required 1 0",
                     bus.HREADYOUT, bus.HRDATA);
        end
        n_checks++;
        if (SPI_SS_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_ss: got %08h required ffffffff", SPI_SS_o);
        end
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %08h required 00000000", d);
        end
        ahb_read(32'h4, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_ssel: got %08h required ffffffff", d);
        end
        ahb_read(32'hC, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rxdata: got %08h required 00000000", d);
        end
    endtask

    task automatic test_ssel();
        logic [31:0] d;
        ahb_write(32'h4, 3'b010, 32'hFFFF_FFFE);
        #1;
        n_checks++;
        if (SPI_SS_o !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL ss_pins: got %08h required fffffffe", SPI_SS_o);
        end
        ahb_read(32'h4, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL ss_readback: got %08h required fffffffe", d);
        end
    endtask

    task automatic test_half_overrun();
        logic [31:0] d;
        int b0, p0, t0;
        b0 = byte_cnt;
        p0 = pulse_total;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h08);
        model_rx = rx_after(model_rx, 32'h0000_1108, 16, p0);
        ahb_write(32'h8, 3'b001, 32'h0000_1108);
        t0 = cyc;
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0000_0201) begin
            n_fail++;
            $display("FAIL half_busy: status=%08h required 00000201", d);
        end
        ahb_write(32'h8, 3'b000, 32'h0000_00AA);
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0000_0221) begin
            n_fail++;
            $display("FAIL overrun_set: status=%08h required 00000221", d);
        end
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0000_0201) begin
            n_fail++;
            $display("FAIL overrun_clear: status=%08h required 00000201", d);
        end
        while (cyc < t0 + 126) @(posedge HCLK);
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0000_0101) begin
            n_fail++;
            $display("FAIL half_last_cycle: status=%08h required 00000101", d);
        end
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL half_done: status=%08h required 00000010", d);
        end
        n_checks++;
        if (last_fall_cyc - t0 != 128) begin
            n_fail++;
            $display("FAIL half_duration: got %0d cycles required 128", last_fall_cyc - t0);
        end
        n_checks++;
        if (pulse_total - p0 != 16) begin
            n_fail++;
            $display("FAIL half_pulses: got %0d required 16", pulse_total - p0);
        end
        check_bytes(b0);
        ahb_read(32'hC, d);
        n_checks++;
        if (d !== model_rx) begin
            n_fail++;
            $display("FAIL half_rxdata: got %08h required %08h", d, model_rx);
        end
    endtask

    task automatic test_word_burst();
        logic [31:0] d;
        int b0, p0;
        b0 = byte_cnt;
        p0 = pulse_total;
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        model_rx = rx_after(model_rx, 32'hDEAD_BEEF, 32, p0);
        ahb_write(32'h8, 3'b010, 32'hDEAD_BEEF);
        wait_done(d);
        n_checks++;
        if (d !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL word_done: status=%08h required 00000010", d);
        end
        n_checks++;
        if (pulse_total - p0 != 32) begin
            n_fail++;
            $display("FAIL word_pulses: got %0d required 32", pulse_total - p0);
        end
        check_bytes(b0);
        ahb_read(32'hC, d);
        n_checks++;
        if (d !== model_rx) begin
            n_fail++;
            $display("FAIL word_rxdata: got %08h required %08h", d, model_rx);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int b0, p0, guard;
        p0 = pulse_total;
        ahb_write(32'h8, 3'b010, 32'hC3C3_5A5A);
        guard = 0;
        while (pulse_total < p0 + 5 && guard < 400) begin
            @(posedge HCLK);
            guard++;
        end
        #1 HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        model_rx = 32'h0;
        @(negedge HCLK);
        n_checks++;
        if (SPI_CLK_o !== 1'b0 || SPI_SS_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL abort_pins: clk=%b ss=%08h required 0 ffffffff", SPI_CLK_o, SPI_SS_o);
        end
        n_checks++;
        if (pulse_total - p0 != 5) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d required 5", pulse_total - p0);
        end
        ahb_read(32'h0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_status: got %08h required 00000000", d);
        end
        ahb_write(32'h4, 3'b010, 32'hFFFF_FFFE);
        b0 = byte_cnt;
        p0 = pulse_total;
        exp_q.push_back(8'h5C);
        model_rx = rx_after(model_rx, 32'h0000_005C, 8, p0);
        ahb_write(32'h8, 3'b000, 32'h0000_005C);
        wait_done(d);
        n_checks++;
        if (pulse_total - p0 != 8) begin
            n_fail++;
            $display("FAIL after_abort_pulses: got %0d required 8", pulse_total - p0);
        end
        check_bytes(b0);
        ahb_read(32'hC, d);
        n_checks++;
        if (d !== model_rx) begin
            n_fail++;
            $display("FAIL after_abort_rxdata: got %08h required %08h", d, model_rx);
        end
    endtask

    initial begin
        bus.HSEL   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HADDR  = 32'h0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b000;
        bus.HTRANS = 2'b00;
        bus.HWDATA = 32'h0;
        model_rx   = 32'h0;
        test_reset();
        test_ssel();
        test_half_overrun();
        test_word_burst();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
